med_window_feeder: RTL and testbench

- Upstream stage of the median filter datapath.
- Accepts a raster-order pixel stream of one image frame and buffers two previous lines.
- For every interior pixel it emits the 3x3 neighbourhood as a 9-beat serial burst (DO, DSO high for 9 cycles), which is the input format of the median core.
- Holds further input until the median core signals completion of the current window.

---
 rtl/med_pkg.sv | 13 +
 rtl/med_line_buf.sv | 28 ++
 rtl/med_window_feeder.sv | 162 ++++++++++++++++
 tb/tb_med_window_feeder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/med_pkg.sv
// Shared types and constants for the median-filter window feeder.
package med_pkg;

   typedef enum logic [1:0] {
      ACCEPT,
      EMIT,
      WAIT
   } feederState_t;

   localparam int WIN_SIZE = 9;
   localparam int BEAT_W   = $clog2(WIN_SIZE);

endpackage

// File: rtl/med_line_buf.sv
// One image line of pixel storage: synchronous write, asynchronous read,
// a single address per cycle shared by both.
module med_line_buf
   import med_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IMG_W = 16,
   localparam int ADDR_W = $clog2(IMG_W)
) (
   input  logic              CLK,
   input  logic              writeEn,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wrData,
   output logic [WIDTH-1:0]  rdData
);

   logic [WIDTH-1:0] mem [IMG_W];

   // Contents need no reset: the first two lines of a frame never emit a window.
   always_ff @(posedge CLK) begin
      if (writeEn) begin
         mem[addr] <= wrData;
      end
   end

   assign rdData = mem[addr];

endmodule

// File: rtl/med_window_feeder.sv
// Buffers two lines of a raster pixel stream and serialises every interior
// 3x3 neighbourhood as a 9-beat burst. Optional EOF output: MED_FEEDER_EOF_EN.
module med_window_feeder
   import med_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IMG_W = 16,
   parameter int IMG_H = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] PIX,
   input  logic             PIX_VALID,
   output logic             PIX_READY,
   output logic [WIDTH-1:0] DO,
   output logic             DSO,
   input  logic             MED_DONE
`ifdef MED_FEEDER_EOF_EN
   ,output logic            EOF
`endif
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);

   feederState_t               state, nextState;
   logic [COL_W-1:0]           col;
   logic [ROW_W-1:0]           row;
   logic [BEAT_W-1:0]          beat, nextBeat;
   logic [WIN_SIZE*WIDTH-1:0]  win, winShifted;
   logic [WIDTH-1:0]           lb0Rd, lb1Rd, nextDo;
   logic                       nextDso, accept, completes, lastCol, lastRow;

   assign PIX_READY = (state == ACCEPT) && !RST;
   assign accept    = PIX_VALID && PIX_READY;
   assign lastCol   = (col == COL_W'(IMG_W - 1));
   assign lastRow   = (row == ROW_W'(IMG_H - 1));
   assign completes = (row >= ROW_W'(2)) && (col >= COL_W'(2));

   med_line_buf #(.WIDTH(WIDTH), .IMG_W(IMG_W)) lb0 (
      .CLK    (CLK),
      .writeEn(accept),
      .addr   (col),
      .wrData (PIX),
      .rdData (lb0Rd)
   );

   med_line_buf #(.WIDTH(WIDTH), .IMG_W(IMG_W)) lb1 (
      .CLK    (CLK),
      .writeEn(accept),
      .addr   (col),
      .wrData (lb0Rd),
      .rdData (lb1Rd)
   );

   // Window held row-major (TL at index 0); a new right column comes from the
   // two line buffers plus the incoming pixel.
   always_comb begin
      winShifted = win;
      for (int r = 0; r < 3; r++) begin
         winShifted[(r*3)*WIDTH   +: WIDTH] = win[(r*3+1)*WIDTH +: WIDTH];
         winShifted[(r*3+1)*WIDTH +: WIDTH] = win[(r*3+2)*WIDTH +: WIDTH];
      end
      winShifted[2*WIDTH +: WIDTH] = lb1Rd;
      winShifted[5*WIDTH +: WIDTH] = lb0Rd;
      winShifted[8*WIDTH +: WIDTH] = PIX;
   end

   always_ff @(posedge CLK) begin
      if (accept) begin
         win <= winShifted;
      end
   end

   // Raster position of the next pixel to be accepted.
   always_ff @(posedge CLK) begin
      if (RST) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (lastCol) begin
            col <= '0;
            row <= lastRow ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

`ifdef MED_FEEDER_EOF_EN
   logic lastWin, nextEof;

   always_ff @(posedge CLK) begin
      if (RST) begin
         lastWin <= 1'b0;
      end else if (accept) begin
         lastWin <= lastRow && lastCol;
      end
   end
`endif

   // Beat 0 is loaded from the freshly shifted window on the accepting edge,
   // so the burst starts on the very next cycle.
   always_comb begin
      nextState = state;
      nextBeat  = beat;
      nextDo    = '0;
      nextDso   = 1'b0;
`ifdef MED_FEEDER_EOF_EN
      nextEof   = 1'b0;
`endif
      case (state)
         ACCEPT: begin
            if (accept && completes) begin
               nextState = EMIT;
               nextBeat  = '0;
               nextDso   = 1'b1;
               nextDo    = winShifted[WIDTH-1:0];
            end
         end
         EMIT: begin
            if (beat == BEAT_W'(WIN_SIZE - 1)) begin
               nextState = WAIT;
            end else begin
               nextBeat = beat + 1'b1;
               nextDso  = 1'b1;
               nextDo   = win[int'(nextBeat)*WIDTH +: WIDTH];
`ifdef MED_FEEDER_EOF_EN
               nextEof  = (nextBeat == BEAT_W'(WIN_SIZE - 1)) && lastWin;
`endif
            end
         end
         WAIT: begin
            if (MED_DONE) begin
               nextState = ACCEPT;
            end
         end
         default: nextState = ACCEPT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ACCEPT;
         beat  <= '0;
         DO    <= '0;
         DSO   <= 1'b0;
`ifdef MED_FEEDER_EOF_EN
         EOF   <= 1'b0;
`endif
      end else begin
         state <= nextState;
         beat  <= nextBeat;
         DO    <= nextDo;
         DSO   <= nextDso;
`ifdef MED_FEEDER_EOF_EN
         EOF   <= nextEof;
`endif
      end
   end

endmodule

// File: tb/tb_med_window_feeder.sv
// Bench for med_window_feeder on a 4x4 frame: bursts are compared against
// windows cut straight out of the frame image; handshake rules checked per cycle.
module tb_med_window_feeder;

   localparam int WIDTH = 8;
   localparam int IMG_W = 4;
   localparam int IMG_H = 4;
   localparam int NPIX  = IMG_W * IMG_H;
   localparam int NWIN  = (IMG_W - 2) * (IMG_H - 2);

   logic             CLK = 1'b0;
   logic             RST;
   logic [WIDTH-1:0] PIX;
   logic             PIX_VALID;
   logic             PIX_READY;
   logic [WIDTH-1:0] DO;
   logic             DSO;
   logic             MED_DONE;
`ifdef MED_FEEDER_EOF_EN
   logic             EOF;
`endif

   med_window_feeder #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .PIX      (PIX),
      .PIX_VALID(PIX_VALID),
      .PIX_READY(PIX_READY),
      .DO       (DO),
      .DSO      (DSO),
      .MED_DONE (MED_DONE)
`ifdef MED_FEEDER_EOF_EN
      ,.EOF     (EOF)
`endif
   );

   always #5 CLK = ~CLK;

   int               assertCount = 0;
   int               failCount   = 0;
   logic [WIDTH-1:0] frame [NPIX];
   logic [71:0]      expQ[$];
   int               expIdxQ[$];
   logic             doneApplied = 1'b0;
   int               windowsSeen;

   task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference: every interior window cut directly from the frame image.
   task automatic buildExpected();
      logic [71:0] vec;
      expQ.delete();
      expIdxQ.delete();
      for (int r = 2; r < IMG_H; r++) begin
         for (int c = 2; c < IMG_W; c++) begin
            vec = '0;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  vec[(i*3+j)*8 +: 8] = frame[(r-2+i)*IMG_W + (c-2+j)];
            expQ.push_back(vec);
            expIdxQ.push_back(r*IMG_W + c);
         end
      end
   endtask

   task automatic fillRamp();
      for (int i = 0; i < NPIX; i++) frame[i] = WIDTH'(i);
   endtask

   task automatic fillRandom();
      for (int i = 0; i < NPIX; i++) frame[i] = WIDTH'($urandom);
   endtask

   task automatic applyReset();
      RST = 1'b1;
      PIX_VALID = 1'b0;
      MED_DONE = 1'b0;
      doneApplied = 1'b0;
      @(negedge CLK);
      checkOutput("rstDso", DSO, 1'b0);
      checkOutput("rstDo", DO, '0);
      checkOutput("rstReady", PIX_READY, 1'b0);
`ifdef MED_FEEDER_EOF_EN
      checkOutput("rstEof", EOF, 1'b0);
`endif
      RST = 1'b0;
      @(negedge CLK);
      checkOutput("readyAfterRst", PIX_READY, 1'b1);
      checkOutput("dsoAfterRst", DSO, 1'b0);
   endtask

   // Streams one frame; resetBeat >= 0 asserts RST at that beat of the first burst.
   task automatic applyStimulus(input int doneDelay, input int validPct, input int earlyBeat, input int resetBeat);
      int idx = 0, burstLen = 0, countdown = 0, cycles = 0, prevAccept = -1;
      bit inBurst = 0, waiting = 0;
      logic [71:0] burstVec = '0;
      logic [71:0] expVec;
      buildExpected();
      windowsSeen = 0;
      forever begin
         @(negedge CLK);
         cycles++;
         MED_DONE = 1'b0;
         if (doneApplied) begin
            checkOutput("readyAfterDone", PIX_READY, 1'b1);
            doneApplied = 1'b0;
         end
         if (DSO) begin
            if (!inBurst) begin
               inBurst = 1;
               burstLen = 0;
               burstVec = '0;
               checkOutput("burstStartPixel", 72'(prevAccept), 72'(expIdxQ.size() > 0 ? expIdxQ[0] : -2));
            end
            checkOutput("readyDuringEmit", PIX_READY, 1'b0);
`ifdef MED_FEEDER_EOF_EN
            checkOutput("eof", EOF, (burstLen == 8) && (expQ.size() == 1));
`endif
            if (burstLen < 9) burstVec[burstLen*8 +: 8] = DO;
            if (burstLen == earlyBeat) MED_DONE = 1'b1;
            if (burstLen == resetBeat) begin
               applyReset();
               return;
            end
            burstLen++;
         end else if (inBurst) begin
            inBurst = 0;
            windowsSeen++;
            checkOutput("burstLen", 72'(burstLen), 72'(9));
            expVec = (expQ.size() > 0) ? expQ.pop_front() : 'x;
            if (expIdxQ.size() > 0) void'(expIdxQ.pop_front());
            checkOutput("burstData", burstVec, expVec);
            waiting = 1;
            countdown = doneDelay;
         end
         if (waiting) begin
            checkOutput("readyInWait", PIX_READY, 1'b0);
            if (countdown == 0) begin
               MED_DONE = 1'b1;
               waiting = 0;
               doneApplied = 1'b1;
            end else begin
               countdown--;
            end
         end
         PIX_VALID = (idx < NPIX) && ($urandom_range(99) < validPct);
         PIX = (idx < NPIX) ? frame[idx] : WIDTH'($urandom);
         prevAccept = (PIX_VALID && PIX_READY) ? idx : -1;
         if (PIX_VALID && PIX_READY) idx++;
         if (idx == NPIX && !inBurst && !waiting && expQ.size() == 0) break;
         if (cycles > 1500) begin
            checkOutput("frameTimeout", 72'(cycles), 72'(0));
            break;
         end
      end
      PIX_VALID = 1'b0;
      if (doneApplied) begin
         @(negedge CLK);
         MED_DONE = 1'b0;
         checkOutput("readyAfterDone", PIX_READY, 1'b1);
         doneApplied = 1'b0;
      end
      checkOutput("windowsPerFrame", 72'(windowsSeen), 72'(NWIN));
   endtask

   initial begin
      RST = 1'b1;
      PIX = '0;
      PIX_VALID = 1'b0;
      MED_DONE = 1'b0;
      repeat (2) @(negedge CLK);
      checkOutput("initDso", DSO, 1'b0);
      checkOutput("initDo", DO, '0);
      checkOutput("initReady", PIX_READY, 1'b0);
      RST = 1'b0;
      @(negedge CLK);
      checkOutput("initReadyAfter", PIX_READY, 1'b1);

      $display("[TB] ramp frame, done after 2 cycles");
      fillRamp();
      applyStimulus(2, 100, -1, -1);

      $display("[TB] ramp frame, done after 20 cycles");
      applyStimulus(20, 100, -1, -1);

      $display("[TB] done pulsed in emit beat 4 and in wait");
      applyStimulus(6, 100, 4, -1);

      $display("[TB] two back-to-back frames with gaps in valid");
      applyStimulus(0, 60, -1, -1);
      applyStimulus(1, 60, -1, -1);

      $display("[TB] reset at emit beat 5, then full frame");
      applyStimulus(2, 100, -1, 5);
      applyStimulus(2, 100, -1, -1);

      $display("[TB] random pixel frames");
      for (int f = 0; f < 3; f++) begin
         fillRandom();
         applyStimulus(int'($urandom_range(6)), int'($urandom_range(100, 40)), -1, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

endmodule
